// File: rtl/jesd204b_pkg.sv
// Shared JESD204B lane constants: K-code octets, symbol width, running-disparity encoding
// and the 8b/10b sub-block tables used by the lane encoder.
package jesd204b_pkg;

  localparam int SYM_W = 10;

  localparam logic RD_NEG = 1'b0;
  localparam logic RD_POS = 1'b1;

  localparam logic [7:0] K28_0 = 8'h1C;  // /R/
  localparam logic [7:0] K28_1 = 8'h3C;
  localparam logic [7:0] K28_2 = 8'h5C;
  localparam logic [7:0] K28_3 = 8'h7C;  // /A/
  localparam logic [7:0] K28_4 = 8'h9C;  // /Q/
  localparam logic [7:0] K28_5 = 8'hBC;  // /K/
  localparam logic [7:0] K28_6 = 8'hDC;
  localparam logic [7:0] K28_7 = 8'hFC;  // /F/
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K30_7 = 8'hFE;

  // 5b/6b data codes in their RD- form, written abcdei with a in the MSB.
  function automatic logic [5:0] enc_5b6b(input logic [4:0] x);
    case (x)
      5'd0:  return 6'b100111;  5'd1:  return 6'b011101;
      5'd2:  return 6'b101101;  5'd3:  return 6'b110001;
      5'd4:  return 6'b110101;  5'd5:  return 6'b101001;
      5'd6:  return 6'b011001;  5'd7:  return 6'b111000;
      5'd8:  return 6'b111001;  5'd9:  return 6'b100101;
      5'd10: return 6'b010101;  5'd11: return 6'b110100;
      5'd12: return 6'b001101;  5'd13: return 6'b101100;
      5'd14: return 6'b011100;  5'd15: return 6'b010111;
      5'd16: return 6'b011011;  5'd17: return 6'b100011;
      5'd18: return 6'b010011;  5'd19: return 6'b110010;
      5'd20: return 6'b001011;  5'd21: return 6'b101010;
      5'd22: return 6'b011010;  5'd23: return 6'b111010;
      5'd24: return 6'b110011;  5'd25: return 6'b100110;
      5'd26: return 6'b010110;  5'd27: return 6'b110110;
      5'd28: return 6'b001110;  5'd29: return 6'b101110;
      5'd30: return 6'b011110;  default: return 6'b101011;
    endcase
  endfunction

  // 3b/4b data codes in their RD- form, fghj with f in the MSB (primary x.7).
  function automatic logic [3:0] enc_3b4b(input logic [2:0] y);
    case (y)
      3'd0: return 4'b1011;  3'd1: return 4'b1001;
      3'd2: return 4'b0101;  3'd3: return 4'b1100;
      3'd4: return 4'b1101;  3'd5: return 4'b1010;
      3'd6: return 4'b0110;  default: return 4'b1110;
    endcase
  endfunction

  function automatic logic k_is_legal(input logic [7:0] octet);
    return (octet[4:0] == 5'd28) || (octet == K23_7) || (octet == K27_7) ||
           (octet == K29_7) || (octet == K30_7);
  endfunction

endpackage

// File: rtl/jesd204b_8b10b_octet.sv
// Combinational single-octet 8b/10b encoder; unlisted K requests are replaced by K28.5.
module jesd204b_8b10b_octet
  import jesd204b_pkg::*;
(
  input  logic [7:0]       data,
  input  logic             k,
  input  logic             rd_in,
  output logic [SYM_W-1:0] symbol,
  output logic             rd_out,
  output logic             k_err
);

  logic [4:0] x;
  logic [2:0] y;
  logic [5:0] six_neg;
  logic [5:0] six;
  logic [3:0] four_neg;
  logic [3:0] four;
  logic       six_unbal;
  logic       rd6;
  logic       alt7;
  logic       k_neutral;

  always_comb begin
    k_err = k && !k_is_legal(data);
    {y, x} = k_err ? K28_5 : data;

    six_neg = (k && x == 5'd28) ? 6'b001111 : enc_5b6b(x);
    // Every RD- 6b entry carries 3 (neutral) or 4 (+2) ones, so even parity means unbalanced.
    six_unbal = ~^six_neg;
    six = (rd_in == RD_POS && (six_unbal || x == 5'd7)) ? ~six_neg : six_neg;
    rd6 = six_unbal ? ~rd_in : rd_in;

    alt7 = (y == 3'd7) &&
           (k || (rd6 == RD_NEG && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                 (rd6 == RD_POS && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
    four_neg = alt7 ? 4'b0111 : enc_3b4b(y);
    k_neutral = k && (y == 3'd1 || y == 3'd2 || y == 3'd5 || y == 3'd6);

    // Neutral K trailers are inverted w.r.t. the data code to keep the comma property.
    if (k_neutral)
      four = (rd6 == RD_NEG) ? ~four_neg : four_neg;
    else if (rd6 == RD_POS && (y == 3'd0 || y == 3'd3 || y == 3'd4 || y == 3'd7))
      four = ~four_neg;
    else
      four = four_neg;

    rd_out = (y == 3'd0 || y == 3'd4 || y == 3'd7) ? ~rd6 : rd6;

    symbol = {four[0], four[1], four[2], four[3],
              six[0], six[1], six[2], six[3], six[4], six[5]};
  end

endmodule

// File: rtl/jesd204b_8b10b_enc.sv
// Per-lane 8b/10b encoder, 2-cycle latency: stage 1 encodes every octet for both starting
// disparities, stage 2 resolves the RD chain. Define JESD_ENC_KCHECK_EN to expose err_k.
module jesd204b_8b10b_enc
  import jesd204b_pkg::*;
#(
  parameter int LANE_DATA_WIDTH = 32,
  parameter int OCTET_PER_SENT  = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic [LANE_DATA_WIDTH-1:0]        in_data,
  input  logic [OCTET_PER_SENT-1:0]         in_k,
  output logic                              out_valid,
  output logic [SYM_W*OCTET_PER_SENT-1:0]   out_symbols,
  output logic                              out_rd
`ifdef JESD_ENC_KCHECK_EN
  ,
  output logic [OCTET_PER_SENT-1:0]         err_k
`endif
);

  logic [OCTET_PER_SENT-1:0][SYM_W-1:0] sym_neg;
  logic [OCTET_PER_SENT-1:0][SYM_W-1:0] sym_pos;
  logic [OCTET_PER_SENT-1:0]            rdo_neg;
  logic [OCTET_PER_SENT-1:0]            rdo_pos;
  logic [OCTET_PER_SENT-1:0]            kerr_c;
  logic [OCTET_PER_SENT-1:0]            kerr_pos_unused;

  logic                                 s1_valid_reg;
  logic [OCTET_PER_SENT-1:0][SYM_W-1:0] sym_neg_reg;
  logic [OCTET_PER_SENT-1:0][SYM_W-1:0] sym_pos_reg;
  logic [OCTET_PER_SENT-1:0]            rdo_neg_reg;
  logic [OCTET_PER_SENT-1:0]            rdo_pos_reg;

  logic [OCTET_PER_SENT:0]              rd_chain;
  logic [OCTET_PER_SENT-1:0][SYM_W-1:0] sym_sel;

  genvar gi;
  generate
    for (gi = 0; gi < OCTET_PER_SENT; gi++) begin : g_oct
      jesd204b_8b10b_octet u_enc_neg (
        .data   (in_data[8*gi +: 8]),
        .k      (in_k[gi]),
        .rd_in  (RD_NEG),
        .symbol (sym_neg[gi]),
        .rd_out (rdo_neg[gi]),
        .k_err  (kerr_c[gi])
      );
      jesd204b_8b10b_octet u_enc_pos (
        .data   (in_data[8*gi +: 8]),
        .k      (in_k[gi]),
        .rd_in  (RD_POS),
        .symbol (sym_pos[gi]),
        .rd_out (rdo_pos[gi]),
        .k_err  (kerr_pos_unused[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        sym_neg_reg <= sym_neg;
        sym_pos_reg <= sym_pos;
        rdo_neg_reg <= rdo_neg;
        rdo_pos_reg <= rdo_pos;
      end
    end
  end

  // out_rd doubles as the stored running disparity feeding octet 0.
  always_comb begin
    rd_chain    = '0;
    sym_sel     = '0;
    rd_chain[0] = out_rd;
    for (int n = 0; n < OCTET_PER_SENT; n++) begin
      sym_sel[n]    = rd_chain[n] ? sym_pos_reg[n] : sym_neg_reg[n];
      rd_chain[n+1] = rd_chain[n] ? rdo_pos_reg[n] : rdo_neg_reg[n];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_symbols <= '0;
      out_rd      <= RD_NEG;
    end else begin
      out_valid <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_symbols <= sym_sel;
        out_rd      <= rd_chain[OCTET_PER_SENT];
      end
    end
  end

`ifdef JESD_ENC_KCHECK_EN
  logic [OCTET_PER_SENT-1:0] kerr_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      kerr_reg <= '0;
      err_k    <= '0;
    end else begin
      if (in_valid) kerr_reg <= kerr_c;
      err_k <= s1_valid_reg ? kerr_reg : '0;
    end
  end
`else
  logic kerr_unused;
  assign kerr_unused = |kerr_c;
`endif

endmodule

// File: doc/jesd204b_8b10b_enc.md
# jesd204b_8b10b_enc

Per-lane 8b/10b encoder downstream of the JESD204B data link layer transmitter. Takes OCTET_PER_SENT octets per clock plus per-octet control (K) flags and produces 10-bit code groups with a running disparity chained across octets and cycles. Instantiated once per lane, between the link layer's lane octet output and the serializer/PHY.

## Interface
Parameters:
- LANE_DATA_WIDTH, 32, octet bits per lane per cycle; must equal 8*OCTET_PER_SENT.
- OCTET_PER_SENT, 4, octets encoded per cycle.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  input octets valid this cycle.
- in_data  in  LANE_DATA_WIDTH  octets; octet 0 = [7:0], transmitted first.
- in_k  in  OCTET_PER_SENT  bit n=1: octet n is a control character.
- out_valid  out  1  out_symbols valid.
- out_symbols  out  10*OCTET_PER_SENT  code groups; symbol n = [10n+9:10n].
- out_rd  out  1  running disparity after last emitted symbol (0 = RD-, 1 = RD+).
- err_k  out  OCTET_PER_SENT  illegal K request flags (present only with JESD_ENC_KCHECK_EN).

## Operation
- Symbol bit order: bit 0 = a, 1 = b, 2 = c, 3 = d, 4 = e, 5 = i, 6 = f, 7 = g, 8 = h, 9 = j; bit 0 serialized first.
- Standard IEEE 802.3 clause 36 5b/6b + 3b/4b tables; D.x.A7 alternate encoding for x = 17, 18, 20 with RD-, and x = 11, 13, 14 with RD+.
- K encoding for K28.0–K28.7, K23.7, K27.7, K29.7, K30.7. JESD204B uses K28.5 (0xBC, /K/), K28.0 (0x1C, /R/), K28.3 (0x7C, /A/), K28.4 (0x9C, /Q/), K28.7 (0xFC, /F/).
- Disparity chain: octet 0 encoded with the stored RD; octet n uses the RD after octet n-1. Stored RD updated to the RD after octet OCTET_PER_SENT-1.
- Sub-block rule: a 6b/4b sub-block with disparity ±2 flips RD; a neutral sub-block keeps RD, except 000111/111000 and 0011/1100, which set RD per standard.
- in_valid = 0: no encode, stored RD held, out_valid = 0 on the corresponding output cycle, out_symbols hold previous value.
- Undefined K request (in_k=1, non-listed octet): encoded as K28.5 at current RD. err_k asserted only when the macro is on.

## Timing
- Latency 2 cycles, in_valid → out_valid.
  - Stage 1 registers the table lookups (both RD variants per octet).
  - Stage 2 resolves the disparity chain and registers the outputs.
- Full throughput, one word per cycle, no backpressure.
- Reset values: out_valid = 0, out_symbols = 0, out_rd = 0 (RD-), err_k = 0, stored RD = RD-, both pipeline valids = 0.
- Reset mid-stream: in-flight words discarded. The first valid word after reset is encoded from RD-.
- out_rd changes only on cycles where out_valid = 1.

## Configuration
- JESD_ENC_KCHECK_EN defined:
  - err_k port exists.
  - err_k[n] = 1 in the same cycle as out_valid when octet n requested an unlisted K code; otherwise 0.
- Undefined: port absent, no check logic. Substitution with K28.5 still occurs.

## Structure
- Shared package jesd204b_pkg holds:
  - K-code octet constants (K28_0, K28_3, K28_4, K28_5, K28_7, etc.).
  - Symbol width constant (10).
  - RD encoding (RD_NEG = 0, RD_POS = 1).
- One sub-module, jesd204b_8b10b_octet: combinational single-octet encoder (data, k, rd_in → symbol, rd_out, k_err). Instantiated OCTET_PER_SENT times, chained through rd.

## Test plan
- Reset, then 4×K28.5 (in_data 0xBCBCBCBC, in_k 4'hF) → two cycles later out_symbols 0x283_17C_283_17C (symbols 3..0 = 0x283, 0x17C, 0x283, 0x17C), out_rd = 0.
- After reset, 4×D21.5 (0xB5B5B5B5, in_k 0) → every symbol 0x155, out_rd stays 0.
- After reset, D0.0 on octet 0 (0x00) → symbol 0 = 0x0B9, RD after octet 0 = RD-.
- Alternate 0xBC single-K words with in_valid gaps of 3 cycles → symbols alternate 0x17C/0x283 across valid words, out_valid = 0 in gaps, RD held.
- Assert reset while stored RD = RD+ → out_valid = 0, out_rd = 0. Next K28.5 encodes 0x17C.
- With JESD_ENC_KCHECK_EN: in_k = 4'h1, in_data[7:0] = 0x00 → err_k = 4'b0001, symbol 0 = K28.5 encoding.
- Without JESD_ENC_KCHECK_EN: same stimulus → symbol 0 = K28.5 encoding, no err_k port.
